matrix_by_vector_scheduler: RTL and testbench

//  Sequences row_by_vector_with_control over a full matrix-by-vector product (rows x no_of_multiples NI-wide chunks).

---
 rtl/matrix_by_vector_scheduler.sv | 201 ++++++++++++++++++++
 tb/tb_matrix_by_vector_scheduler.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/matrix_by_vector_scheduler.sv
// Sequences a row-by-vector unit over a whole matrix-by-vector product: issues chunk reads,
// starts each row, advances chunks on consumption and writes row results back in row order.
module matrix_by_vector_scheduler #(
   parameter int NI              = 8,
   parameter int element_width   = 32,
   parameter int MAX_OUTSTANDING = 4
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     start,
   input  logic [31:0]              no_of_rows,
   input  logic [31:0]              no_of_multiples,
   input  logic                     give_me_only,
   input  logic                     decoder_read_now,
   input  logic [element_width-1:0] row_result,
   output logic                     start_row_by_vector,
   output logic                     you_can_read,
   output logic                     mem_rd_en,
   output logic [31:0]              mem_row_addr,
   output logic [31:0]              mem_chunk_idx,
   output logic                     result_wr_en,
   output logic [31:0]              result_addr,
   output logic [element_width-1:0] result_data,
   output logic                     busy,
   output logic                     done,
   output logic                     error
);

   typedef enum logic [2:0] {S_IDLE, S_ISSUE, S_FEED, S_DRAIN, S_DONE} state_t;

   // Reject parameter sets the row unit cannot be paired with.
   if (NI < 1 || MAX_OUTSTANDING < 2 || MAX_OUTSTANDING > 15) begin : g_bad_params
      $error("matrix_by_vector_scheduler: illegal parameter value");
   end

   state_t                   state_reg, state_next;
   logic [31:0]              rows_reg, rows_next;
   logic [31:0]              mult_reg, mult_next;
   logic [31:0]              row_cnt_reg, row_cnt_next;
   logic [31:0]              outstanding_reg, outstanding_next;
   logic [31:0]              retired_reg, retired_next;
   logic                     start_row_reg, start_row_next;
   logic                     you_can_read_reg, you_can_read_next;
   logic                     mem_rd_en_reg, mem_rd_en_next;
   logic [31:0]              mem_row_addr_reg, mem_row_addr_next;
   logic [31:0]              mem_chunk_idx_reg, mem_chunk_idx_next;
   logic                     result_wr_en_reg, result_wr_en_next;
   logic [31:0]              result_addr_reg, result_addr_next;
   logic [element_width-1:0] result_data_reg, result_data_next;
   logic                     busy_reg, busy_next;
   logic                     done_reg, done_next;
   logic                     error_reg, error_next;
   logic                     complete, retire;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_reg         <= S_IDLE;
         rows_reg          <= '0;
         mult_reg          <= '0;
         row_cnt_reg       <= '0;
         outstanding_reg   <= '0;
         retired_reg       <= '0;
         start_row_reg     <= 1'b0;
         you_can_read_reg  <= 1'b0;
         mem_rd_en_reg     <= 1'b0;
         mem_row_addr_reg  <= '0;
         mem_chunk_idx_reg <= '0;
         result_wr_en_reg  <= 1'b0;
         result_addr_reg   <= '0;
         result_data_reg   <= '0;
         busy_reg          <= 1'b0;
         done_reg          <= 1'b0;
         error_reg         <= 1'b0;
      end else begin
         state_reg         <= state_next;
         rows_reg          <= rows_next;
         mult_reg          <= mult_next;
         row_cnt_reg       <= row_cnt_next;
         outstanding_reg   <= outstanding_next;
         retired_reg       <= retired_next;
         start_row_reg     <= start_row_next;
         you_can_read_reg  <= you_can_read_next;
         mem_rd_en_reg     <= mem_rd_en_next;
         mem_row_addr_reg  <= mem_row_addr_next;
         mem_chunk_idx_reg <= mem_chunk_idx_next;
         result_wr_en_reg  <= result_wr_en_next;
         result_addr_reg   <= result_addr_next;
         result_data_reg   <= result_data_next;
         busy_reg          <= busy_next;
         done_reg          <= done_next;
         error_reg         <= error_next;
      end
   end

   always_comb begin
      state_next         = state_reg;
      rows_next          = rows_reg;
      mult_next          = mult_reg;
      row_cnt_next       = row_cnt_reg;
      outstanding_next   = outstanding_reg;
      retired_next       = retired_reg;
      start_row_next     = 1'b0;
      you_can_read_next  = you_can_read_reg;
      mem_rd_en_next     = 1'b0;
      mem_row_addr_next  = mem_row_addr_reg;
      mem_chunk_idx_next = mem_chunk_idx_reg;
      result_wr_en_next  = 1'b0;
      result_addr_next   = result_addr_reg;
      result_data_next   = result_data_reg;
      busy_next          = busy_reg;
      done_next          = 1'b0;
      error_next         = error_reg;
      complete           = 1'b0;
      retire             = 1'b0;

      // Retire path runs alongside the sequencer so results never wait on issue activity.
      if (state_reg != S_IDLE && decoder_read_now) begin
         if (outstanding_reg == 32'd0) begin
            error_next = 1'b1;
         end else begin
            retire            = 1'b1;
            result_wr_en_next = 1'b1;
            result_addr_next  = retired_reg;
            result_data_next  = row_result;
            retired_next      = retired_reg + 32'd1;
         end
      end

      case (state_reg)
         S_IDLE: begin
            if (start) begin
               rows_next          = no_of_rows;
               mult_next          = no_of_multiples;
               row_cnt_next       = '0;
               outstanding_next   = '0;
               retired_next       = '0;
               mem_row_addr_next  = '0;
               mem_chunk_idx_next = '0;
               busy_next          = 1'b1;
               error_next         = 1'b0;
               if (no_of_rows == 32'd0 || no_of_multiples == 32'd0) begin
                  error_next = 1'b1;
                  state_next = S_DONE;
               end else begin
                  state_next = S_ISSUE;
               end
            end
            if (decoder_read_now) error_next = 1'b1;
         end
         S_ISSUE: begin
            if (outstanding_reg != 32'(MAX_OUTSTANDING)) begin
               mem_rd_en_next     = 1'b1;
               start_row_next     = 1'b1;
               you_can_read_next  = 1'b1;
               mem_chunk_idx_next = '0;
               mem_row_addr_next  = row_cnt_reg;
               state_next         = S_FEED;
            end
         end
         S_FEED: begin
            if (give_me_only) begin
               if (mem_chunk_idx_reg < mult_reg - 32'd1) begin
                  mem_chunk_idx_next = mem_chunk_idx_reg + 32'd1;
                  mem_rd_en_next     = 1'b1;
               end else begin
                  complete          = 1'b1;
                  row_cnt_next      = row_cnt_reg + 32'd1;
                  you_can_read_next = 1'b0;
                  state_next        = (row_cnt_reg + 32'd1 < rows_reg) ? S_ISSUE : S_DRAIN;
               end
            end
         end
         S_DRAIN: begin
            if (retired_next == rows_reg) state_next = S_DONE;
         end
         S_DONE: begin
            done_next  = 1'b1;
            busy_next  = 1'b0;
            state_next = S_IDLE;
         end
         default: state_next = S_IDLE;
      endcase

      // Completing and retiring in the same cycle cancel out.
      if (complete && !retire)      outstanding_next = outstanding_reg + 32'd1;
      else if (retire && !complete) outstanding_next = outstanding_reg - 32'd1;
   end

   assign start_row_by_vector = start_row_reg;
   assign you_can_read        = you_can_read_reg;
   assign mem_rd_en           = mem_rd_en_reg;
   assign mem_row_addr        = mem_row_addr_reg;
   assign mem_chunk_idx       = mem_chunk_idx_reg;
   assign result_wr_en        = result_wr_en_reg;
   assign result_addr         = result_addr_reg;
   assign result_data         = result_data_reg;
   assign busy                = busy_reg;
   assign done                = done_reg;
   assign error               = error_reg;

endmodule

// File: tb/tb_matrix_by_vector_scheduler.sv
// Directed bench for matrix_by_vector_scheduler; the bench acts as the row unit and
// checks strobes, ordering, stalls, error handling and asynchronous reset.
module tb_matrix_by_vector_scheduler;

   logic        clk = 1'b0;
   logic        reset = 1'b0;
   logic        start = 1'b0;
   logic [31:0] no_of_rows = '0;
   logic [31:0] no_of_multiples = '0;
   logic        give_me_only = 1'b0;
   logic        decoder_read_now = 1'b0;
   logic [31:0] row_result = '0;
   logic        start_row_by_vector, you_can_read, mem_rd_en, result_wr_en, busy, done, error;
   logic [31:0] mem_row_addr, mem_chunk_idx, result_addr, result_data;

   int checks = 0;
   int errors = 0;
   int n_start = 0, n_rd = 0, n_done = 0;
   int chunk_q[$], row_q[$], addr_q[$], data_q[$];
   int b_start, b_rd, b_done, b_rdq, b_wrq;

   matrix_by_vector_scheduler #(.NI(8), .element_width(32), .MAX_OUTSTANDING(4)) dut (
      .clk(clk), .reset(reset), .start(start), .no_of_rows(no_of_rows),
      .no_of_multiples(no_of_multiples), .give_me_only(give_me_only),
      .decoder_read_now(decoder_read_now), .row_result(row_result),
      .start_row_by_vector(start_row_by_vector), .you_can_read(you_can_read),
      .mem_rd_en(mem_rd_en), .mem_row_addr(mem_row_addr), .mem_chunk_idx(mem_chunk_idx),
      .result_wr_en(result_wr_en), .result_addr(result_addr), .result_data(result_data),
      .busy(busy), .done(done), .error(error)
   );

   always #5 clk = ~clk;

   // Event recorder sampled on the falling edge, mid-cycle.
   always @(negedge clk) begin
      if (start_row_by_vector) n_start++;
      if (done) n_done++;
      if (mem_rd_en) begin
         n_rd++;
         chunk_q.push_back(int'(mem_chunk_idx));
         row_q.push_back(int'(mem_row_addr));
      end
      if (result_wr_en) begin
         addr_q.push_back(int'(result_addr));
         data_q.push_back(int'(result_data));
      end
   end

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(negedge clk);
      #1;
   endtask

   task automatic mark();
      b_start = n_start; b_rd = n_rd; b_done = n_done;
      b_rdq = chunk_q.size(); b_wrq = addr_q.size();
   endtask

   task automatic start_job(input int rows, input int mult);
      no_of_rows = 32'(rows);
      no_of_multiples = 32'(mult);
      start = 1'b1;
      tick();
      start = 1'b0;
   endtask

   task automatic wait_ycr();
      int n = 0;
      while (you_can_read !== 1'b1 && n < 60) begin
         tick();
         n++;
      end
      chk("wait_you_can_read", 64'(you_can_read), 64'd1);
   endtask

   task automatic feed_row(input int mult);
      for (int c = 0; c < mult; c++) begin
         wait_ycr();
         give_me_only = 1'b1;
         tick();
         give_me_only = 1'b0;
      end
   endtask

   task automatic pulse_result(input int value);
      decoder_read_now = 1'b1;
      row_result = 32'(value);
      tick();
      decoder_read_now = 1'b0;
   endtask

   task automatic wait_done();
      int n = 0;
      while (done !== 1'b1 && n < 100) begin
         tick();
         n++;
      end
      chk("wait_done", 64'(done), 64'd1);
      tick();
   endtask

   initial begin
      // Reset state
      repeat (3) tick();
      chk("rst_ctrl", 64'({start_row_by_vector, you_can_read, mem_rd_en, result_wr_en, busy, done, error}), 64'd0);
      chk("rst_bus", 64'(mem_row_addr | mem_chunk_idx | result_addr | result_data), 64'd0);
      reset = 1'b1;
      tick();

      // Stray result in IDLE: ignored, flags error
      mark();
      pulse_result(99);
      tick();
      chk("idle_dec_error", 64'(error), 64'd1);
      chk("idle_dec_nowrite", 64'(addr_q.size() - b_wrq), 64'd0);

      // rows=3, mult=1, reply 4 cycles after each row start
      mark();
      start_job(3, 1);
      chk("t1_busy", 64'(busy), 64'd1);
      chk("t1_error_cleared", 64'(error), 64'd0);
      for (int r = 0; r < 3; r++) begin
         feed_row(1);
         repeat (3) tick();
         pulse_result(100 + r);
      end
      wait_done();
      repeat (2) tick();
      chk("t1_starts", 64'(n_start - b_start), 64'd3);
      chk("t1_done_once", 64'(n_done - b_done), 64'd1);
      chk("t1_writes", 64'(addr_q.size() - b_wrq), 64'd3);
      for (int i = 0; i < 3; i++) begin
         chk($sformatf("t1_addr%0d", i), 64'(addr_q[b_wrq + i]), 64'(i));
         chk($sformatf("t1_data%0d", i), 64'(data_q[b_wrq + i]), 64'(100 + i));
      end
      chk("t1_busy_low", 64'(busy), 64'd0);

      // rows=2, mult=3: chunk sequence and read count
      mark();
      start_job(2, 3);
      feed_row(3);
      pulse_result(55);
      feed_row(3);
      pulse_result(66);
      wait_done();
      chk("t2_starts", 64'(n_start - b_start), 64'd2);
      chk("t2_reads", 64'(n_rd - b_rd), 64'd6);
      for (int i = 0; i < 6; i++) begin
         chk($sformatf("t2_chunk%0d", i), 64'(chunk_q[b_rdq + i]), 64'(i % 3));
         chk($sformatf("t2_row%0d", i), 64'(row_q[b_rdq + i]), 64'(i / 3));
      end
      chk("t2_data1", 64'(data_q[b_wrq + 1]), 64'd66);

      // rows=8, results withheld: stall at 4 outstanding
      mark();
      start_job(8, 1);
      for (int r = 0; r < 4; r++) feed_row(1);
      repeat (6) tick();
      chk("t3_stall_starts", 64'(n_start - b_start), 64'd4);
      chk("t3_stall_ycr", 64'(you_can_read), 64'd0);
      chk("t3_stall_reads", 64'(n_rd - b_rd), 64'd4);
      pulse_result(200);
      feed_row(1);
      repeat (6) tick();
      chk("t3_release_one", 64'(n_start - b_start), 64'd5);
      pulse_result(201);
      feed_row(1);
      pulse_result(202);
      feed_row(1);
      pulse_result(203);
      // Final chunk consumed in the same cycle as a retire
      wait_ycr();
      give_me_only = 1'b1;
      decoder_read_now = 1'b1;
      row_result = 32'd204;
      tick();
      give_me_only = 1'b0;
      decoder_read_now = 1'b0;
      chk("t3_outstanding_eq", 64'(dut.outstanding_reg), 64'd3);
      pulse_result(205);
      pulse_result(206);
      chk("t3_no_early_done", 64'(n_done - b_done), 64'd0);
      pulse_result(207);
      chk("t3_writes8", 64'(addr_q.size() - b_wrq), 64'd8);
      chk("t3_done_not_yet", 64'(done), 64'd0);
      tick();
      chk("t3_done_after_last", 64'(done), 64'd1);
      for (int i = 0; i < 8; i++) begin
         chk($sformatf("t3_addr%0d", i), 64'(addr_q[b_wrq + i]), 64'(i));
         chk($sformatf("t3_data%0d", i), 64'(data_q[b_wrq + i]), 64'(200 + i));
      end
      chk("t3_error", 64'(error), 64'd0);
      tick();

      // rows=0: error, done two cycles after start, no traffic
      mark();
      start_job(0, 1);
      chk("t4_busy", 64'(busy), 64'd1);
      chk("t4_error", 64'(error), 64'd1);
      chk("t4_done_early", 64'(done), 64'd0);
      tick();
      chk("t4_done", 64'(done), 64'd1);
      chk("t4_busy_fall", 64'(busy), 64'd0);
      tick();
      chk("t4_done_pulse", 64'(done), 64'd0);
      chk("t4_no_reads", 64'(n_rd - b_rd), 64'd0);
      chk("t4_no_writes", 64'(addr_q.size() - b_wrq), 64'd0);
      start_job(1, 1);
      chk("t4_error_cleared", 64'(error), 64'd0);
      feed_row(1);
      pulse_result(77);
      wait_done();

      // Reset asserted in the middle of FEED
      start_job(2, 3);
      feed_row(1);
      #2 reset = 1'b0;
      #1;
      chk("t5_async_ctrl", 64'({start_row_by_vector, you_can_read, mem_rd_en, result_wr_en, busy, done, error}), 64'd0);
      chk("t5_async_bus", 64'(mem_row_addr | mem_chunk_idx | result_addr | result_data), 64'd0);
      tick();
      reset = 1'b1;
      tick();
      mark();
      start_job(2, 3);
      feed_row(3);
      pulse_result(300);
      feed_row(3);
      pulse_result(301);
      wait_done();
      chk("t5_reads", 64'(n_rd - b_rd), 64'd6);
      chk("t5_first_row", 64'(row_q[b_rdq]), 64'd0);
      chk("t5_first_chunk", 64'(chunk_q[b_rdq]), 64'd0);
      chk("t5_last_row", 64'(row_q[b_rdq + 5]), 64'd1);
      chk("t5_addr0", 64'(addr_q[b_wrq]), 64'd0);
      chk("t5_addr1", 64'(addr_q[b_wrq + 1]), 64'd1);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
